// File: rtl/moo_seq_if.sv
// Handshake and control bundle between the mode-of-operation sequencer and its
// neighbours: bus front end, input/output block buffers, data-in register, AES core.
interface moo_seq_if #(
    parameter int BLK_W = 16
);
    logic             clr_core;
    logic             start;
    logic             cfg_mode;
    logic             cfg_ctr_w;
    logic [BLK_W-1:0] cfg_blk_num;
    logic             din_vld;
    logic             din_rd;
    logic             dout_rdy;
    logic             dout_wr;
    logic             aes_start;
    logic             aes_done;
    logic             ecb_di_en;
    logic             ecb_iv_en;
    logic             ecb_di_clr;
    logic             ctr_4b;
    logic             ctr_4w;
    logic             busy;
    logic             done;
    logic [BLK_W-1:0] blk_left;

    modport slave (
        input  clr_core, start, cfg_mode, cfg_ctr_w, cfg_blk_num,
        input  din_vld, dout_rdy, aes_done,
        output din_rd, dout_wr, aes_start,
        output ecb_di_en, ecb_iv_en, ecb_di_clr, ctr_4b, ctr_4w,
        output busy, done, blk_left
    );

    modport master (
        output clr_core, start, cfg_mode, cfg_ctr_w, cfg_blk_num,
        output din_vld, dout_rdy, aes_done,
        input  din_rd, dout_wr, aes_start,
        input  ecb_di_en, ecb_iv_en, ecb_di_clr, ctr_4b, ctr_4w,
        input  busy, done, blk_left
    );
endinterface

// File: rtl/moo_seq.sv
// Block sequencer for ECB/CTR: steps the data-in register and AES core once per
// 128-bit block and handshakes with the input and output block buffers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; config sampled on start
// IVLD     | CTR: load IV/counter into data-in register
// WAIT_IN  | ECB: waiting for an input block
// LOAD     | ECB: load input block, pop input buffer
// START    | pulse AES start
// WAIT_AES | waiting for AES completion
// WAIT_OUT | waiting for output space (and input block in CTR), then push
// INC      | CTR: increment counter (32-bit or 128-bit)
// INCW     | CTR 128-bit: let the ripple increment settle
// DONE     | completion pulse, clear data-in register
module moo_seq #(
    parameter int BLK_W     = 16,
    parameter int INCW_WAIT = 4
) (
    input logic        clk,
    input logic        rst_n,
    moo_seq_if.slave   bus
);
    localparam int WCNT_W = (INCW_WAIT > 1) ? $clog2(INCW_WAIT) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_IVLD,
        ST_WAIT_IN,
        ST_LOAD,
        ST_START,
        ST_WAIT_AES,
        ST_WAIT_OUT,
        ST_INC,
        ST_INCW,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_mode;
    logic              r_ctr_w;
    logic [BLK_W-1:0]  r_blk_left;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_busy;
    logic              r_done;
    logic              r_di_clr;
    logic              r_di_en;
    logic              r_iv_en;
    logic              r_aes_start;
    logic              r_ctr_4b;
    logic              r_ctr_4w;
    logic              r_wout;
    logic              w_hs;

    // Output transfer is the only Mealy path: gated by a registered state flag
    // so it depends on the buffer handshakes, not on a state decode.
    assign w_hs = r_wout & bus.dout_rdy & (~r_mode | bus.din_vld) & ~bus.clr_core;

    assign bus.dout_wr    = w_hs;
    assign bus.din_rd     = r_di_en | (w_hs & r_mode);
    assign bus.aes_start  = r_aes_start;
    assign bus.ecb_di_en  = r_di_en;
    assign bus.ecb_iv_en  = r_iv_en;
    assign bus.ecb_di_clr = r_di_clr;
    assign bus.ctr_4b     = r_ctr_4b;
    assign bus.ctr_4w     = r_ctr_4w;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.blk_left   = r_blk_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_ctr_w     <= 1'b0;
            r_blk_left  <= '0;
            r_wcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_di_clr    <= 1'b0;
            r_di_en     <= 1'b0;
            r_iv_en     <= 1'b0;
            r_aes_start <= 1'b0;
            r_ctr_4b    <= 1'b0;
            r_ctr_4w    <= 1'b0;
            r_wout      <= 1'b0;
        end else begin
            // Strobes are set only on entry to their state, so each lasts one cycle.
            r_done      <= 1'b0;
            r_di_clr    <= 1'b0;
            r_di_en     <= 1'b0;
            r_iv_en     <= 1'b0;
            r_aes_start <= 1'b0;
            r_ctr_4b    <= 1'b0;
            r_ctr_4w    <= 1'b0;

            if (bus.clr_core) begin
                r_state    <= ST_IDLE;
                r_blk_left <= '0;
                r_wcnt     <= '0;
                r_busy     <= 1'b0;
                r_wout     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_mode     <= bus.cfg_mode;
                            r_ctr_w    <= bus.cfg_ctr_w;
                            r_blk_left <= bus.cfg_blk_num;
                            r_busy     <= 1'b1;
                            if (bus.cfg_blk_num == '0) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_di_clr <= 1'b1;
                            end else if (bus.cfg_mode) begin
                                r_state <= ST_IVLD;
                                r_iv_en <= 1'b1;
                            end else begin
                                r_state <= ST_WAIT_IN;
                            end
                        end
                    end
                    ST_IVLD: begin
                        r_state     <= ST_START;
                        r_aes_start <= 1'b1;
                    end
                    ST_WAIT_IN: begin
                        if (bus.din_vld) begin
                            r_state <= ST_LOAD;
                            r_di_en <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        r_state     <= ST_START;
                        r_aes_start <= 1'b1;
                    end
                    ST_START: begin
                        r_state <= ST_WAIT_AES;
                    end
                    ST_WAIT_AES: begin
                        if (bus.aes_done) begin
                            r_state <= ST_WAIT_OUT;
                            r_wout  <= 1'b1;
                        end
                    end
                    ST_WAIT_OUT: begin
                        if (w_hs) begin
                            r_wout     <= 1'b0;
                            r_blk_left <= r_blk_left - BLK_W'(1);
                            if (r_blk_left == BLK_W'(1)) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_di_clr <= 1'b1;
                            end else if (r_mode) begin
                                r_state  <= ST_INC;
                                r_ctr_4w <= r_ctr_w;
                                r_ctr_4b <= ~r_ctr_w;
                            end else begin
                                r_state <= ST_WAIT_IN;
                            end
                        end
                    end
                    ST_INC: begin
                        if (r_ctr_w && (INCW_WAIT > 0)) begin
                            r_state <= ST_INCW;
                            r_wcnt  <= WCNT_W'(INCW_WAIT - 1);
                        end else begin
                            r_state     <= ST_START;
                            r_aes_start <= 1'b1;
                        end
                    end
                    ST_INCW: begin
                        if (r_wcnt == '0) begin
                            r_state     <= ST_START;
                            r_aes_start <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt - WCNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_wout  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_moo_seq.sv
// Directed bench for moo_seq: expected strobe events are queued per run and
// matched (vector, blk_left, cycle spacing) as the sequencer emits them.
module tb_moo_seq;
    localparam int BLK_W = 16;

    localparam logic [9:0] E_ST   = 10'h200;
    localparam logic [9:0] E_RD   = 10'h100;
    localparam logic [9:0] E_WR   = 10'h080;
    localparam logic [9:0] E_AES  = 10'h040;
    localparam logic [9:0] E_DIEN = 10'h020;
    localparam logic [9:0] E_IV   = 10'h010;
    localparam logic [9:0] E_CLR  = 10'h008;
    localparam logic [9:0] E_C4B  = 10'h004;
    localparam logic [9:0] E_C4W  = 10'h002;
    localparam logic [9:0] E_DN   = 10'h001;

    typedef struct {
        logic [9:0] v;
        int         bl;
        int         gap;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   acnt;
    ev_t  q[$];

    moo_seq_if #(.BLK_W(BLK_W)) bus ();

    moo_seq #(.BLK_W(BLK_W), .INCW_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [9:0] v, input int bl, input int gap);
        ev_t e;
        e.v   = v;
        e.bl  = bl;
        e.gap = gap;
        q.push_back(e);
    endtask

    function automatic logic [9:0] vec();
        return {bus.start, bus.din_rd, bus.dout_wr, bus.aes_start, bus.ecb_di_en,
                bus.ecb_iv_en, bus.ecb_di_clr, bus.ctr_4b, bus.ctr_4w, bus.done};
    endfunction

    // AES core model: aes_done three cycles after aes_start
    initial begin
        acnt = 0;
        bus.aes_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.aes_done = 1'b0;
            if (acnt > 0) begin
                acnt--;
                if (acnt == 0) bus.aes_done = 1'b1;
            end
            if (bus.aes_start === 1'b1) acnt = 3;
        end
    end

    // Scoreboard: every cycle with any strobe (or start) pops one expected event
    initial begin
        int         cyc;
        int         last;
        logic [9:0] v;
        ev_t        e;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                v = vec();
                if (v != 10'h0) begin
                    if (q.size() == 0) begin
                        check("unexpected_evt", 32'(v), 32'h0);
                    end else begin
                        e = q.pop_front();
                        check("evt_vec", 32'(v), 32'(e.v));
                        check("evt_blk_left", 32'(bus.blk_left), e.bl);
                        if (e.gap >= 0) check("evt_gap", cyc - last, e.gap);
                    end
                    last = cyc;
                end
            end
        end
    end

    task automatic pulse_start(input logic m, input logic w, input int n, input int len);
        @(posedge clk); #1;
        bus.cfg_mode    = m;
        bus.cfg_ctr_w   = w;
        bus.cfg_blk_num = BLK_W'(n);
        bus.start       = 1'b1;
        for (int i = 1; i < len; i++) begin
            @(posedge clk); #1;
            bus.cfg_mode    = ~m;
            bus.cfg_blk_num = BLK_W'(7);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check(tag, 32'(bus.busy), 32'h0);
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        int seen;
        n_pass          = 0;
        n_total         = 0;
        rst_n           = 1'b0;
        bus.clr_core    = 1'b0;
        bus.start       = 1'b0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_ctr_w   = 1'b0;
        bus.cfg_blk_num = '0;
        bus.din_vld     = 1'b1;
        bus.dout_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_blk_left", 32'(bus.blk_left), 32'h0);
        check("rst_strobes", 32'(vec()), 32'h0);

        // ECB, 2 blocks
        push(E_ST, 0, -1);
        push(E_RD | E_DIEN, 2, 2);
        push(E_AES, 2, 1);
        push(E_WR, 2, 4);
        push(E_RD | E_DIEN, 1, 2);
        push(E_AES, 1, 1);
        push(E_WR, 1, 4);
        push(E_DN | E_CLR, 0, 1);
        pulse_start(1'b0, 1'b0, 2, 1);
        wait_idle("ecb_idle");

        // CTR 32-bit, 3 blocks
        push(E_ST, 0, -1);
        push(E_IV, 3, 1);
        push(E_AES, 3, 1);
        push(E_RD | E_WR, 3, 4);
        push(E_C4B, 2, 1);
        push(E_AES, 2, 1);
        push(E_RD | E_WR, 2, 4);
        push(E_C4B, 1, 1);
        push(E_AES, 1, 1);
        push(E_RD | E_WR, 1, 4);
        push(E_DN | E_CLR, 0, 1);
        pulse_start(1'b1, 1'b0, 3, 1);
        wait_idle("ctr32_idle");

        // CTR 128-bit, 2 blocks; start held into IVLD with other config is ignored
        push(E_ST, 0, -1);
        push(E_ST | E_IV, 2, 1);
        push(E_AES, 2, 1);
        push(E_RD | E_WR, 2, 4);
        push(E_C4W, 1, 1);
        push(E_AES, 1, 5);
        push(E_RD | E_WR, 1, 4);
        push(E_DN | E_CLR, 0, 1);
        pulse_start(1'b1, 1'b1, 2, 2);
        wait_idle("ctr128_idle");

        // CTR backpressure on output then input
        bus.dout_rdy = 1'b0;
        bus.din_vld  = 1'b0;
        push(E_ST, 0, -1);
        push(E_IV, 1, 1);
        push(E_AES, 1, 1);
        push(E_RD | E_WR, 1, 15);
        push(E_DN | E_CLR, 0, 1);
        pulse_start(1'b1, 1'b0, 1, 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (bus.aes_done) break;
        end
        check("bp_aes_done", 32'(bus.aes_done), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_rd", 32'(bus.din_rd), 32'h0);
            check("bp_no_wr", 32'(bus.dout_wr), 32'h0);
        end
        @(posedge clk); #1 bus.dout_rdy = 1'b1;
        @(negedge clk);
        check("bp_half_wr", 32'(bus.dout_wr), 32'h0);
        check("bp_half_rd", 32'(bus.din_rd), 32'h0);
        @(posedge clk); #1 bus.din_vld = 1'b1;
        @(negedge clk);
        check("bp_both", 32'({bus.din_rd, bus.dout_wr}), 32'h3);
        wait_idle("bp_idle");

        // clr_core in WAIT_AES of block 2 of 4, then a normal run
        push(E_ST, 0, -1);
        push(E_RD | E_DIEN, 4, 2);
        push(E_AES, 4, 1);
        push(E_WR, 4, 4);
        push(E_RD | E_DIEN, 3, 2);
        push(E_AES, 3, 1);
        pulse_start(1'b0, 1'b0, 4, 1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.aes_start) seen++;
            if (seen == 2) break;
        end
        check("clr_aes_starts", seen, 2);
        @(posedge clk); #1 bus.clr_core = 1'b1;
        @(posedge clk); #1 bus.clr_core = 1'b0;
        @(negedge clk);
        check("clr_busy", 32'(bus.busy), 32'h0);
        check("clr_blk_left", 32'(bus.blk_left), 32'h0);
        check("clr_done", 32'(bus.done), 32'h0);
        repeat (6) @(negedge clk);
        check("clr_queue", q.size(), 0);
        push(E_ST, 0, -1);
        push(E_RD | E_DIEN, 1, 2);
        push(E_AES, 1, 1);
        push(E_WR, 1, 4);
        push(E_DN | E_CLR, 0, 1);
        pulse_start(1'b0, 1'b0, 1, 1);
        wait_idle("after_clr_idle");

        // zero blocks, start held into DONE
        push(E_ST, 0, -1);
        push(E_ST | E_DN | E_CLR, 0, 1);
        pulse_start(1'b0, 1'b0, 0, 2);
        @(negedge clk);
        check("blk0_busy_after", 32'(bus.busy), 32'h0);
        wait_idle("blk0_idle");
        check("blk0_blk_left", 32'(bus.blk_left), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
